// File: rtl/bubble_drive8_if.sv
// Host-side bus of the bubble cartridge emulator.
// The host drives the bubble field, mode and buffer-write lines; the device drives streams and strobes.
interface bubble_drive8_if;
    logic        clock_out;
    logic        bubble_shift_enable;
    logic        replicator_enable;
    logic        bootloop_enable;
    logic [2:0]  image_dip_switch;
    logic        bubble_out_odd;
    logic        bubble_out_even;
    logic [10:0] bubble_buffer_write_address;
    logic [1:0]  bubble_buffer_write_data_input;
    logic        bubble_buffer_write_enable;
    logic        bubble_buffer_write_clock;
    logic        load_page;
    logic        load_bootloader;

    modport master (
        output bubble_shift_enable,
        output replicator_enable,
        output bootloop_enable,
        output image_dip_switch,
        output bubble_buffer_write_address,
        output bubble_buffer_write_data_input,
        output bubble_buffer_write_enable,
        output bubble_buffer_write_clock,
        input  clock_out,
        input  bubble_out_odd,
        input  bubble_out_even,
        input  load_page,
        input  load_bootloader
    );

    modport slave (
        input  bubble_shift_enable,
        input  replicator_enable,
        input  bootloop_enable,
        input  image_dip_switch,
        input  bubble_buffer_write_address,
        input  bubble_buffer_write_data_input,
        input  bubble_buffer_write_enable,
        input  bubble_buffer_write_clock,
        output clock_out,
        output bubble_out_odd,
        output bubble_out_even,
        output load_page,
        output load_bootloader
    );
endinterface

// File: rtl/bubble_drive8_top.sv
// Magnetic-bubble cartridge emulator: 2048x2 page buffer replayed as odd/even serial streams.
// Bootloader-loop and page-replication readout, divided clock and loader request strobes.
module bubble_drive8_top #(
    parameter int CLK_DIV       = 4,
    parameter int BUBBLE_PERIOD = 120,
    parameter int ACCESS_DELAY  = 8,
    parameter int BOOT_LEN      = 1920,
    parameter int PAGE_LEN      = 584
) (
    input  logic           master_clock,
    input  logic           power_good,
    bubble_drive8_if.slave bus
);

    localparam int DELAY_CLKS = ACCESS_DELAY * BUBBLE_PERIOD;
    localparam int CNT_MAX    = (DELAY_CLKS > BUBBLE_PERIOD) ? DELAY_CLKS : BUBBLE_PERIOD;
    localparam int CNT_W      = $clog2(CNT_MAX) + 1;
    localparam int HALF       = CLK_DIV / 2;
    localparam int DIV_W      = $clog2(HALF) + 1;

    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CLKS - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BUBBLE_PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(HALF - 1);
    localparam logic [10:0]      BOOT_LAST  = 11'(BOOT_LEN - 1);
    localparam logic [10:0]      PAGE_LAST  = 11'(PAGE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // Control bits: [4] shift_enable, [3] replicator, [2] bootloop, [1] write_enable, [0] write_clock.
    logic [4:0]  ctl_s1;
    logic [4:0]  ctl_s2;
    logic [2:0]  edge_q;
    logic [12:0] wbus_s1;
    logic [12:0] wbus_s2;

    logic        bse_fall;
    logic        bse_rise;
    logic        rep_fall;
    logic        wclk_rise;
    logic        start_boot;
    logic        start_page;
    logic        wr_en;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [10:0]      addr_q;
    logic [10:0]      last_q;

    logic [1:0]       mem [0:2047];
    logic [1:0]       rd_q;
    logic             out_en_q;
    logic             out_en_d;
    logic             load_page_q;
    logic             load_page_d;
    logic             load_boot_q;
    logic             boot_done_q;
    logic [DIV_W-1:0] div_q;
    logic             clk_out_q;

    // The image select only matters to the external loader.
    logic unused_dip;
    assign unused_dip = ^bus.image_dip_switch;

    // Two-flop synchronizers plus a third stage for edge detection on the strobes.
    always_ff @(posedge master_clock) begin
        if (!power_good) begin
            ctl_s1  <= '0;
            ctl_s2  <= '0;
            edge_q  <= '0;
            wbus_s1 <= '0;
            wbus_s2 <= '0;
        end else begin
            ctl_s1  <= {bus.bubble_shift_enable,
                        bus.replicator_enable,
                        bus.bootloop_enable,
                        bus.bubble_buffer_write_enable,
                        bus.bubble_buffer_write_clock};
            ctl_s2  <= ctl_s1;
            edge_q  <= {ctl_s2[4], ctl_s2[3], ctl_s2[0]};
            wbus_s1 <= {bus.bubble_buffer_write_address,
                        bus.bubble_buffer_write_data_input};
            wbus_s2 <= wbus_s1;
        end
    end

    assign bse_fall  = edge_q[2] & ~ctl_s2[4];
    assign bse_rise  = ~edge_q[2] & ctl_s2[4];
    assign rep_fall  = edge_q[1] & ~ctl_s2[3];
    assign wclk_rise = ~edge_q[0] & ctl_s2[0];

    assign start_boot = bse_fall & ~ctl_s2[2];
    assign start_page = rep_fall & ~ctl_s2[4] & ctl_s2[2];
    assign wr_en      = power_good & wclk_rise & ~ctl_s2[1];

    // Page buffer: no reset so contents survive power-fail; read is registered (old data on collision).
    always_ff @(posedge master_clock) begin
        if (wr_en) begin
            mem[wbus_s2[12:2]] <= wbus_s2[1:0];
        end
        rd_q <= mem[addr_q];
    end

    // FSM state register.
    always_ff @(posedge master_clock) begin
        if (!power_good) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a rising shift_enable aborts any readout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_boot || start_page) begin
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (bse_rise) begin
                    state_d = IDLE;
                end else if (cnt_q == DELAY_LAST) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bse_rise) begin
                    state_d = IDLE;
                end else if (cnt_q == BIT_LAST && addr_q == last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: stream gate keeps the last entry for its full period; load_page only on accepted starts.
    always_comb begin
        out_en_d    = (state_q == SHIFT) && !bse_rise;
        load_page_d = (state_q == IDLE) && start_page;
    end

    // Timing and address counters; length latched at the start event.
    always_ff @(posedge master_clock) begin
        if (!power_good) begin
            cnt_q  <= '0;
            addr_q <= '0;
            last_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q  <= '0;
                    addr_q <= '0;
                    if (start_boot) begin
                        last_q <= BOOT_LAST;
                    end else if (start_page) begin
                        last_q <= PAGE_LAST;
                    end
                end
                DELAY: begin
                    if (cnt_q == DELAY_LAST) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= '0;
                        if (addr_q != last_q) begin
                            addr_q <= addr_q + 11'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q  <= '0;
                    addr_q <= '0;
                end
            endcase
        end
    end

    // Registered strobes and stream gate.
    always_ff @(posedge master_clock) begin
        if (!power_good) begin
            out_en_q    <= 1'b0;
            load_page_q <= 1'b0;
            load_boot_q <= 1'b0;
            boot_done_q <= 1'b0;
        end else begin
            out_en_q    <= out_en_d;
            load_page_q <= load_page_d;
            load_boot_q <= ~boot_done_q;
            boot_done_q <= 1'b1;
        end
    end

    // Clock divider: toggles every HALF master clocks, starting from reset release.
    always_ff @(posedge master_clock) begin
        if (!power_good) begin
            div_q     <= '0;
            clk_out_q <= 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_q     <= '0;
            clk_out_q <= ~clk_out_q;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign bus.bubble_out_odd  = rd_q[1] & out_en_q;
    assign bus.bubble_out_even = rd_q[0] & out_en_q;
    assign bus.load_page       = load_page_q;
    assign bus.load_bootloader = load_boot_q;
    assign bus.clock_out       = clk_out_q;

endmodule

// File: tb/tb_bubble_drive8_top.sv
// Bench for bubble_drive8_top: expected bit pairs queued at each start, compared per bubble period.
// Bubble period shortened so full bootloader and page readouts fit the cycle budget.
module tb_bubble_drive8_top;

    localparam int BP   = 8;
    localparam int AD   = 8;
    localparam int BOOT = 1920;
    localparam int PAGE = 584;
    // Edges from a start drive to first valid bit: 2 sync + edge stage, delay, output register.
    localparam int LAT  = 3 + AD * BP + 1;

    logic master_clock = 1'b0;
    logic power_good;

    bubble_drive8_if bus();

    bubble_drive8_top #(
        .CLK_DIV       (4),
        .BUBBLE_PERIOD (BP),
        .ACCESS_DELAY  (AD),
        .BOOT_LEN      (BOOT),
        .PAGE_LEN      (PAGE)
    ) dut (
        .master_clock (master_clock),
        .power_good   (power_good),
        .bus          (bus)
    );

    always #5 master_clock = ~master_clock;

    int checks   = 0;
    int failures = 0;
    int lp_cnt   = 0;

    logic [1:0] model [0:2047];
    logic [1:0] exp_q [$];
    logic [1:0] pair;
    logic [4:0] outs;

    assign pair = {bus.bubble_out_odd, bus.bubble_out_even};
    assign outs = {bus.clock_out, bus.bubble_out_odd, bus.bubble_out_even,
                   bus.load_page, bus.load_bootloader};

    always @(negedge master_clock) begin
        if (bus.load_page === 1'b1) lp_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge master_clock);
        #1;
    endtask

    function automatic logic [1:0] pat(input int a);
        return 2'(a) ^ 2'(a >> 3) ^ 2'b01;
    endfunction

    task automatic write_word(input int a, input logic [1:0] d, input bit en);
        bus.bubble_buffer_write_address    = 11'(a);
        bus.bubble_buffer_write_data_input = d;
        bus.bubble_buffer_write_enable     = ~en;
        step(1);
        bus.bubble_buffer_write_clock = 1'b1;
        step(4);
        bus.bubble_buffer_write_clock = 1'b0;
        step(4);
        if (en) model[a] = d;
    endtask

    task automatic push_range(input int n, input bit tail);
        for (int i = 0; i < n; i++) exp_q.push_back(model[i]);
        if (tail) exp_q.push_back(2'b00);
    endtask

    // Call right after driving a start; samples each slot mid-period.
    task automatic expect_stream(input string tag);
        int idx;
        logic [1:0] e;
        idx = 0;
        repeat (LAT + BP / 2) @(posedge master_clock);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s[%0d]", tag, idx), 16'(pair), 16'(e));
            idx++;
            if (exp_q.size() > 0) step(BP);
        end
    endtask

    initial begin
        bit found;
        power_good                         = 1'b0;
        bus.bubble_shift_enable            = 1'b1;
        bus.replicator_enable              = 1'b1;
        bus.bootloop_enable                = 1'b0;
        bus.image_dip_switch               = 3'b101;
        bus.bubble_buffer_write_address    = '0;
        bus.bubble_buffer_write_data_input = '0;
        bus.bubble_buffer_write_enable     = 1'b1;
        bus.bubble_buffer_write_clock      = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step(1);
            check("reset_outs", 16'(outs), 16'h0);
        end
        power_good = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check("load_boot", 16'(bus.load_bootloader), 16'(k == 1));
            check("clock_out", 16'(bus.clock_out), 16'((k / 2) % 2));
        end

        for (int a = 0; a < BOOT; a++) write_word(a, pat(a), 1'b1);
        write_word(0, 2'b11, 1'b1);
        write_word(1, 2'b10, 1'b1);
        write_word(2, 2'b01, 1'b1);
        write_word(3, 2'b00, 1'b1);
        write_word(511, 2'b11, 1'b1);
        write_word(1023, 2'b11, 1'b1);
        write_word(1918, 2'b00, 1'b1);
        write_word(1919, 2'b00, 1'b1);

        lp_cnt = 0;
        push_range(BOOT, 1'b1);
        bus.bubble_shift_enable = 1'b0;
        expect_stream("boot");
        check("boot_no_load_page", 16'(lp_cnt), 16'd0);

        write_word(2, 2'b11, 1'b0);

        bus.bootloop_enable = 1'b1;
        step(4);
        lp_cnt = 0;
        push_range(PAGE, 1'b1);
        bus.replicator_enable = 1'b0;
        fork
            begin
                step(7);
                bus.replicator_enable = 1'b1;
                step(2000);
                bus.replicator_enable = 1'b0;
                step(7);
                bus.replicator_enable = 1'b1;
            end
            expect_stream("page");
        join
        check("load_page_cycles", 16'(lp_cnt), 16'd1);

        bus.bubble_shift_enable = 1'b1;
        bus.bootloop_enable     = 1'b0;
        step(4);
        push_range(14, 1'b0);
        bus.bubble_shift_enable = 1'b0;
        expect_stream("pre_abort");
        bus.bubble_shift_enable = 1'b1;
        step(3);
        check("abort_outs", 16'(pair), 16'h0);
        step(2 * BP);
        check("abort_idle", 16'(pair), 16'h0);
        push_range(5, 1'b0);
        bus.bubble_shift_enable = 1'b0;
        expect_stream("restart");

        power_good = 1'b0;
        step(1);
        check("reset_mid_outs", 16'(pair), 16'h0);
        check("reset_mid_lb", 16'(bus.load_bootloader), 16'h0);
        step(2);
        power_good = 1'b1;
        step(1);
        check("relaunch_lb", 16'(bus.load_bootloader), 16'h1);
        step(1);
        check("relaunch_lb_end", 16'(bus.load_bootloader), 16'h0);
        bus.bubble_shift_enable = 1'b1;
        step(4);
        push_range(8, 1'b0);
        bus.bubble_shift_enable = 1'b0;
        expect_stream("readback");

        bus.bubble_shift_enable = 1'b1;
        step(4);
        bus.bubble_shift_enable = 1'b0;
        found = 1'b0;
        for (int i = 0; i < LAT + 16 && !found; i++) begin
            step(1);
            if (pair == 2'b11) found = 1'b1;
        end
        check("first_bit_seen", 16'(found), 16'h1);
        if (found) begin
            for (int i = 1; i < BP; i++) begin
                step(1);
                check("hold_first", 16'(pair), 16'h3);
            end
            step(1);
            check("second_bit", 16'(pair), 16'h2);
        end
        bus.bubble_shift_enable = 1'b1;
        step(4);
        check("final_idle", 16'(pair), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bubble_drive8_top.md
Name: bubble_drive8_top

Overview:
- Emulates a magnetic-bubble memory cartridge for a host controller.
- A 2048 x 2-bit page buffer is filled through a slow strobe-style write port and replayed as serial odd/even bubble streams.
- Two readout modes: bootloader loop, and page replication.
- Also outputs a divided clock and load-request strobes for an external loader.

Parameters:
- CLK_DIV, 4: master clocks per clock_out period; even, ≥2.
- BUBBLE_PERIOD, 120: master clocks per bubble bit position.
- ACCESS_DELAY, 8: bubble periods from start event to first output bit.
- BOOT_LEN, 1920: buffer entries replayed in bootloader mode, starting at address 0.
- PAGE_LEN, 584: buffer entries replayed per page, starting at address 0.

Ports:
- master_clock  in  1  sole clock, rising edge.
- power_good  in  1  synchronous active-low reset (0 = power not good = reset).
- clock_out  out  1  master_clock / CLK_DIV, 50% duty.
- bubble_shift_enable  in  1  active-low; host drives bubble field.
- replicator_enable  in  1  active-low pulse; requests a page read.
- bootloop_enable  in  1  0 = bootloader mode, 1 = page mode.
- image_dip_switch  in  3  image select, passed through to the loader only; no internal effect.
- bubble_out_odd  out  1  serial data, buffer bit[1].
- bubble_out_even  out  1  serial data, buffer bit[0].
- bubble_buffer_write_address  in  11  buffer write address.
- bubble_buffer_write_data_input  in  2  buffer write data.
- bubble_buffer_write_enable  in  1  active-low write enable.
- bubble_buffer_write_clock  in  1  write strobe; treated as data and sampled in the master_clock domain.
- load_page  out  1  one-cycle request to load the next page.
- load_bootloader  out  1  one-cycle request to load the bootloader.

Behaviour:
- Reset (power_good = 0 at a clock edge):
  - clock_out, bubble outputs, load_page and load_bootloader are 0.
  - FSM goes to IDLE; all counters and synchronizers clear.
  - Buffer contents are retained.
  - Reset mid-readout aborts the readout immediately.
- Input synchronization: every host input passes a 2-flop synchronizer; edges are detected on synchronized values.
- Write port:
  - Triggers on a synchronized rising edge of write_clock while synchronized write_enable = 0.
  - Writes the synchronized data to the synchronized address.
  - Strobe high and low phases must each be ≥3 master clocks.
  - Address and data must be stable from 1 clock before the rising edge until it completes.
  - Read-during-write to the same address returns the old data.
- load_bootloader: single 1-cycle pulse on the first clock after reset release.
- load_page: 1-cycle pulse on each accepted replicator start in page mode.
- clock_out: toggles every CLK_DIV/2 clocks; first toggle CLK_DIV/2 clocks after reset release.
- FSM states IDLE, DELAY, SHIFT.
- IDLE -> DELAY on a start event:
  - Bootloader mode start: synchronized falling edge of bubble_shift_enable while bootloop_enable = 0.
  - Page mode start: synchronized falling edge of replicator_enable while bubble_shift_enable = 0 and bootloop_enable = 1.
  - The mode and length (BOOT_LEN or PAGE_LEN) are latched at the start event.
- DELAY -> SHIFT after ACCESS_DELAY x BUBBLE_PERIOD clocks.
- SHIFT:
  - Read address starts at 0 and increments every BUBBLE_PERIOD clocks.
  - {bubble_out_odd, bubble_out_even} = buffer[address], registered; the output is valid 1 clock after the address changes.
  - Each bit pair is held exactly BUBBLE_PERIOD clocks.
  - After the last entry (length-1) is held, outputs go to 0 and the FSM returns to IDLE.
- Abort: in DELAY or SHIFT, a rise of synchronized bubble_shift_enable returns the FSM to IDLE and zeroes the outputs on the next clock.
- Ignored events:
  - Start events during DELAY or SHIFT.
  - bootloop_enable changes during DELAY or SHIFT (takes effect at the next start).
- Address counter: 11 bits; never exceeds length-1, so it does not wrap.
- Outputs are 0 whenever the FSM is not in SHIFT.

Test Plan:
1. Reset and strobes: power_good 0 for 5 clocks, then 1.
   - All outputs are 0 during reset.
   - load_bootloader = 1 for exactly 1 clock after release.
   - clock_out period = 4 clocks.
2. Buffer write and bootloader readout:
   - Write 11, 10, 01, 00 to addresses 0-3, 11 to 511 and 1023, 00 to 1918 and 1919; write_enable low, strobes 4 clocks high and 4 low.
   - With bootloop_enable = 0, drop bubble_shift_enable.
   - After 8 x 120 clocks, odd/even = 1/1, 1/0, 0/1, 0/0, each held 120 clocks; address 511 shows 1/1.
   - Outputs return to 0 after 1920 entries.
3. Write gating: a strobe with write_enable = 1 at address 2 data 11 leaves readout at address 2 = 01.
4. Page replication:
   - Set bootloop_enable = 1, bubble_shift_enable = 0, then pulse replicator_enable low ~7 clocks.
   - load_page pulses 1 clock.
   - Entries 0..583 are replayed after the 960-clock delay, then outputs go to 0.
   - A second replicator pulse mid-page does not pulse load_page and does not restart the readout.
5. Abort: raise bubble_shift_enable during SHIFT.
   - Outputs are 0 within 3 clocks (2-flop synchronizer plus 1 register); FSM is IDLE.
   - The next start begins again at address 0.
6. Reset mid-readout: power_good = 0 during SHIFT.
   - Outputs drop to 0 at the next edge.
   - After release and a new start, previously written data reads back unchanged.
